torus_io_ctrl: RTL
==================

# torus_io_ctrl

Run controller and data buffering for the 2x2 torus PE array. Holds two lane-wise input buffers and two output buffers, one lane per IO PE. On a host start it streams input words onto the array load ports while holding the array busy for a programmed number of cycles, and captures the array store ports into the output buffers. It sits between the host-side access logic and the torus array, driving `Data0_Load`, `Data1_Load` and `PE_Array_Busy`, and consuming `Data0_Store` and `Data1_Store`.

## Interface
- DWIDTH, 32, array data word width (equals array SYS_DWIDTH)
- AWIDTH, 10, buffer address width; each of the 4 buffers is 2^AWIDTH words

- Clk  in  1  single clock; all logic on rising edge
- Resetn  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle run request; honoured only when Ready=1
- Run_Cycles  in  AWIDTH+1  run length N, sampled with Start; 0..2^AWIDTH
- Ready  out  1  controller in IDLE
- Done  out  1  one-cycle pulse at end of run
- Host_Wr_En  in  1  write Host_Wr_Data into input buffer of lane Host_Lane at Host_Addr
- Host_Lane  in  1  lane select (0 = Data0, 1 = Data1) for host write and read
- Host_Addr  in  AWIDTH  host word address
- Host_Wr_Data  in  DWIDTH  host write data
- Host_Rd_Data  out  DWIDTH  output buffer[Host_Lane][Host_Addr], registered, 1-cycle latency
- Data0_Load, Data1_Load  out  DWIDTH  array load words
- Data0_Store, Data1_Store  in  DWIDTH  array store words
- PE_Array_Busy  out  1  array run enable

## Operation
- States: IDLE, PREP, RUN, DONE.
- IDLE: Ready=1. On Start:
  - latch N;
  - clear the cycle counter k to 0;
  - go to PREP if N>0, else go to DONE.
- PREP (1 cycle): issue input buffer reads at address 0 for both lanes; go to RUN.
- RUN (N cycles):
  - PE_Array_Busy=1.
  - In busy cycle k (0..N-1), DataX_Load = in_buf[X][k].
  - Address k+1 is read during cycle k; reads past the end are don't-care.
  - At the edge ending cycle k, write DataX_Store into out_buf[X][k].
  - After cycle N-1, go to DONE.
- DONE (1 cycle): Done=1, then return to IDLE.
- Host writes are accepted only in IDLE and ignored in all other states.
- Host reads of the output buffers are allowed in any state. Reading an address during RUN returns the old or new value, undefined.
- Start outside IDLE is ignored; it is neither queued nor restarts the run.
- Counter k is AWIDTH+1 bits. With N=2^AWIDTH, k indexes the full buffer with no wrap.
- DataX_Load is 0 in every state except RUN.
- Buffers are not cleared by reset. Their contents are preserved across Resetn.

## Timing
- Reset values (asynchronous, immediate on Resetn=0): state IDLE, Ready=1, Done=0, PE_Array_Busy=0, Data0_Load=Data1_Load=0, Host_Rd_Data=0, k=0.
- Start sampled at edge T, where cycle T is the cycle in which Start=1:
  - PREP in cycle T+1;
  - PE_Array_Busy high in cycles T+2 .. T+N+1;
  - Done high in cycle T+N+2;
  - Ready high again from cycle T+N+3.
- N=0: no busy cycles; Done in cycle T+1; Ready in T+2.
- Back-to-back runs: Start asserted in the first Ready cycle after Done gives a new PREP in the following cycle.
- Host_Rd_Data updates at the edge after Host_Addr/Host_Lane are presented.
- Resetn deasserted mid-run:
  - PE_Array_Busy and the load outputs drop to 0 asynchronously;
  - no Done pulse is produced;
  - out_buf words already written are retained.
- Host_Wr_En and Start in the same IDLE cycle: both take effect. The write commits before PREP reads, so a write to address 0 is visible on load cycle 0.

## Test plan
- Reset and idle:
  - Stimulus: assert Resetn=0 mid-cycle.
  - Required response: all outputs at their reset values immediately; Ready=1.
- Basic run:
  - Stimulus: write lane0 addr 0..3 = 0x10..0x13 and lane1 = 0x20..0x23; Start with N=4.
  - Required response: Busy high exactly 4 cycles starting 2 cycles after Start; Data0_Load = 0x10,0x11,0x12,0x13 and Data1_Load = 0x20..0x23 in busy cycles 0..3; Done one cycle after the last busy cycle.
- Store capture:
  - Stimulus: during the basic run, drive Data0_Store = 0xA0+k and Data1_Store = 0xB0+k.
  - Required response: host reads after Done return out_buf lane0 addr 2 = 0xA2 and lane1 addr 3 = 0xB3, each one cycle after the address is applied.
- Boundary lengths:
  - Stimulus: N=0.
  - Required response: Done the cycle after Start, Busy never high.
  - Stimulus: N=1024.
  - Required response: Busy exactly 1024 cycles; in_buf[1023] appears on the last busy cycle.
- Ignored requests:
  - Stimulus: during RUN, pulse Start and issue Host_Wr_En to lane0 addr 1 with 0xDEAD.
  - Required response: run length unchanged; a later run loads the original addr 1 word.
- Reset mid-run:
  - Stimulus: Resetn=0 at busy cycle 2 of an N=8 run, then a fresh Start with N=2.
  - Required response: Busy drops at once and no Done is seen for the aborted run; the new run behaves normally; out_buf addr 0..1 hold the stored values from the new run.

Source files
------------

// File: rtl/torus_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : torus_io_ctrl
// Brief    : Run controller and lane-wise input/output buffering for the
//            2x2 torus PE array.
// Revision : 1.0 - initial release
// ============================================================================
module torus_io_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [AWIDTH:0]   Run_Cycles,
    output logic              Ready,
    output logic              Done,
    input  logic              Host_Wr_En,
    input  logic              Host_Lane,
    input  logic [AWIDTH-1:0] Host_Addr,
    input  logic [DWIDTH-1:0] Host_Wr_Data,
    output logic [DWIDTH-1:0] Host_Rd_Data,
    output logic [DWIDTH-1:0] Data0_Load,
    output logic [DWIDTH-1:0] Data1_Load,
    input  logic [DWIDTH-1:0] Data0_Store,
    input  logic [DWIDTH-1:0] Data1_Store,
    output logic              PE_Array_Busy
);

    localparam int         c_DEPTH = 1 << AWIDTH;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PREP  = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [AWIDTH:0]   r_n;
    logic [AWIDTH:0]   r_k;
    logic [AWIDTH:0]   w_k_inc;
    logic              w_last;
    logic              w_in_rd_en;
    logic [AWIDTH-1:0] w_in_rd_addr;
    logic              w_host_wr;
    logic [DWIDTH-1:0] w_host_rd;
    logic [DWIDTH-1:0] r_load0;
    logic [DWIDTH-1:0] r_load1;
    logic [DWIDTH-1:0] r_host_rd;

    logic [DWIDTH-1:0] r_in_buf0  [c_DEPTH];
    logic [DWIDTH-1:0] r_in_buf1  [c_DEPTH];
    logic [DWIDTH-1:0] r_out_buf0 [c_DEPTH];
    logic [DWIDTH-1:0] r_out_buf1 [c_DEPTH];

    assign w_k_inc      = r_k + 1'b1;
    assign w_last       = (r_k == (r_n - 1'b1));
    assign w_host_wr    = Host_Wr_En && (r_state == c_IDLE);
    assign w_in_rd_en   = (r_state == c_PREP) || (r_state == c_RUN);
    // Prefetch one word ahead so the load register holds word k in busy cycle k.
    assign w_in_rd_addr = (r_state == c_PREP) ? '0 : w_k_inc[AWIDTH-1:0];
    assign w_host_rd    = Host_Lane ? r_out_buf1[Host_Addr] : r_out_buf0[Host_Addr];

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (Start) begin
                    w_state_next = (Run_Cycles != '0) ? c_PREP : c_DONE;
                end
            end
            c_PREP:  w_state_next = c_RUN;
            c_RUN: begin
                if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        Ready         = (r_state == c_IDLE);
        Done          = (r_state == c_DONE);
        PE_Array_Busy = (r_state == c_RUN);
        Data0_Load    = (r_state == c_RUN) ? r_load0 : '0;
        Data1_Load    = (r_state == c_RUN) ? r_load1 : '0;
        Host_Rd_Data  = r_host_rd;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_n       <= '0;
            r_k       <= '0;
            r_host_rd <= '0;
        end else begin
            r_host_rd <= w_host_rd;
            if ((r_state == c_IDLE) && Start) begin
                r_n <= Run_Cycles;
                r_k <= '0;
            end else if (r_state == c_RUN) begin
                r_k <= w_k_inc;
            end
        end
    end

    // Buffer storage carries no reset so contents survive Resetn.
    always_ff @(posedge Clk) begin
        if (w_host_wr && !Host_Lane) begin
            r_in_buf0[Host_Addr] <= Host_Wr_Data;
        end
        if (w_host_wr && Host_Lane) begin
            r_in_buf1[Host_Addr] <= Host_Wr_Data;
        end
        if (w_in_rd_en) begin
            r_load0 <= r_in_buf0[w_in_rd_addr];
            r_load1 <= r_in_buf1[w_in_rd_addr];
        end
        if (r_state == c_RUN) begin
            r_out_buf0[r_k[AWIDTH-1:0]] <= Data0_Store;
            r_out_buf1[r_k[AWIDTH-1:0]] <= Data1_Store;
        end
    end

endmodule
`default_nettype wire
